// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Looks up the fetch PC combinationally, trains on branches resolved in MEM,
// flags mispredictions and keeps saturating branch/mispredict statistics.
module branch_predictor #(
  parameter int ENTRIES = 8,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = 30 - IDX_W
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] if_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_npc,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  output logic        mispredict,
  output logic [31:0] br_count,
  output logic [31:0] mispred_count
);

  // Gray-style ordering: bit 1 is the prediction, one bit flips per step.
  typedef enum logic [1:0] {
    NH = 2'b00,
    NS = 2'b01,
    TS = 2'b11,
    TH = 2'b10
  } bpred_t;

  logic               valid   [ENTRIES];
  logic [TAG_W-1:0]   tags    [ENTRIES];
  logic [31:0]        targets [ENTRIES];
  bpred_t             states  [ENTRIES];

  logic [IDX_W-1:0]   if_idx;
  logic [TAG_W-1:0]   if_tag;
  logic [IDX_W-1:0]   upd_idx;
  logic [TAG_W-1:0]   upd_tag;
  logic               upd_hit;
  logic               unused_pc_low;

  // Saturating counter step: advance toward TH on taken, toward NH otherwise.
  function automatic bpred_t next_state(input bpred_t s, input logic taken);
    bpred_t n;
    n = s;
    if (taken) begin
      case (s)
        NH:      n = NS;
        NS:      n = TS;
        TS:      n = TH;
        default: n = TH;
      endcase
    end else begin
      case (s)
        TH:      n = TS;
        TS:      n = NS;
        NS:      n = NH;
        default: n = NH;
      endcase
    end
    return n;
  endfunction

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign if_idx  = if_pc[IDX_W+1:2];
  assign if_tag  = if_pc[31:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[31:IDX_W+2];

  // Instruction PCs are word aligned; the byte-offset bits carry no information.
  assign unused_pc_low = ^{if_pc[1:0], upd_pc[1:0]};

  // Fetch-side lookup: reads the table as it stood before this cycle's update.
  always_comb begin
    pred_hit   = valid[if_idx] && (tags[if_idx] == if_tag);
    pred_taken = pred_hit && states[if_idx][1];
    pred_npc   = pred_taken ? targets[if_idx] : (if_pc + 32'd4);
  end

  // Resolution-side tag compare and misprediction flag.
  always_comb begin
    upd_hit    = valid[upd_idx] && (tags[upd_idx] == upd_tag);
    mispredict = upd_en && (upd_pred_taken != upd_taken);
  end

  // Table training: advance counter on hit, allocate on taken miss.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i]   <= 1'b0;
        tags[i]    <= '0;
        targets[i] <= 32'd0;
        states[i]  <= NH;
      end
    end else if (upd_en) begin
      if (upd_hit) begin
        states[upd_idx] <= next_state(states[upd_idx], upd_taken);
        if (upd_taken) begin
          targets[upd_idx] <= upd_target;
        end
      end else if (upd_taken) begin
        valid[upd_idx]   <= 1'b1;
        tags[upd_idx]    <= upd_tag;
        targets[upd_idx] <= upd_target;
        states[upd_idx]  <= TS;
      end
    end
  end

  // Branch and misprediction statistics for the CPU tracker.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      br_count      <= 32'd0;
      mispred_count <= 32'd0;
    end else if (upd_en) begin
      br_count <= sat_inc(br_count);
      if (mispredict) begin
        mispred_count <= sat_inc(mispred_count);
      end
    end
  end

endmodule
